// File: rtl/varredor_tabuleiro.sv
// Chess board matrix scanner: row drive, column sync, frame debounce, one strobe per press.
// Optional macro VARREDOR_MULTI_ERR_EN rejects multi-square frames and adds the multiplo flag.
module varredor_tabuleiro #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] linhaAtiva,
  input  logic [7:0] colunasLidas,
  output logic [2:0] jogadaFileira,
  output logic [2:0] jogadaColuna,
  output logic       temJogada,
  output logic [3:0] db_estado
`ifdef VARREDOR_MULTI_ERR_EN
  ,
  output logic       multiplo
`endif
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] D_LAST = DW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    LIVRE         = 2'd0,
    CONFIRMA      = 2'd1,
    EMITE         = 2'd2,
    ESPERA_SOLTAR = 2'd3
  } estado_t;

  logic [7:0]    sync1, sync2;
  logic [DW-1:0] div_q;
  logic [2:0]    row_q;
  logic [1:0]    acc_cnt;
  logic [2:0]    acc_r, acc_c;
  logic          amostra, fim_quadro;
  logic [1:0]    row_cnt, frame_cnt;
  logic [2:0]    row_col, frame_r, frame_c;
  estado_t       estado, estado_nx;
  logic [2:0]    cand_r, cand_c, cand_r_nx, cand_c_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic          ocupado, unico, mesmo;

  assign amostra    = (div_q == D_LAST);
  assign fim_quadro = amostra && (row_q == 3'd7);
  assign db_estado  = {2'b00, estado};

  // Column synchronizer
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 8'd0;
      sync2 <= 8'd0;
    end else begin
      sync1 <= colunasLidas;
      sync2 <= sync1;
    end
  end

  // Row scan: divider plus one-hot drive kept in step with row_q
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q      <= '0;
      row_q      <= 3'd0;
      linhaAtiva <= 8'h01;
    end else if (amostra) begin
      div_q      <= '0;
      row_q      <= row_q + 3'd1;
      linhaAtiva <= {linhaAtiva[6:0], linhaAtiva[7]};
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // Current row analysis merged into the running frame result
  always_comb begin
    row_col = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (sync2[i]) row_col = 3'(i);
    end
    if (sync2 == 8'd0)                         row_cnt = 2'd0;
    else if ((sync2 & (sync2 - 8'd1)) != 8'd0) row_cnt = 2'd2;
    else                                       row_cnt = 2'd1;
    frame_cnt = acc_cnt;
    frame_r   = acc_r;
    frame_c   = acc_c;
    if (amostra) begin
      if (acc_cnt == 2'd0 && row_cnt != 2'd0) begin
        frame_r = row_q;
        frame_c = row_col;
      end
      frame_cnt = (3'(acc_cnt) + 3'(row_cnt) >= 3'd2) ? 2'd2 : 2'(acc_cnt + row_cnt);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || fim_quadro) begin
      acc_cnt <= 2'd0;
      acc_r   <= 3'd0;
      acc_c   <= 3'd0;
    end else if (amostra) begin
      acc_cnt <= frame_cnt;
      acc_r   <= frame_r;
      acc_c   <= frame_c;
    end
  end

  // FSM state and candidate registers
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= LIVRE;
      cand_r <= 3'd0;
      cand_c <= 3'd0;
      cnt_q  <= '0;
    end else begin
      estado <= estado_nx;
      cand_r <= cand_r_nx;
      cand_c <= cand_c_nx;
      cnt_q  <= cnt_nx;
    end
  end

  always_comb begin
    estado_nx = estado;
    cand_r_nx = cand_r;
    cand_c_nx = cand_c;
    cnt_nx    = cnt_q;
    ocupado   = (frame_cnt != 2'd0);
`ifdef VARREDOR_MULTI_ERR_EN
    unico     = (frame_cnt == 2'd1);
`else
    unico     = ocupado;
`endif
    mesmo     = (frame_r == cand_r) && (frame_c == cand_c);
    case (estado)
      LIVRE: begin
        if (fim_quadro && unico) begin
          estado_nx = CONFIRMA;
          cand_r_nx = frame_r;
          cand_c_nx = frame_c;
          cnt_nx    = CW'(1);
        end
      end
      CONFIRMA: begin
        if (fim_quadro) begin
          if (!ocupado || !unico) begin
            estado_nx = LIVRE;
            cnt_nx    = '0;
          end else if (mesmo) begin
            cnt_nx = cnt_q + CW'(1);
            if (cnt_q + CW'(1) == CW'(DEBOUNCE)) estado_nx = EMITE;
          end else begin
            cand_r_nx = frame_r;
            cand_c_nx = frame_c;
            cnt_nx    = CW'(1);
          end
        end
      end
      EMITE: begin
        estado_nx = ESPERA_SOLTAR;
        cnt_nx    = '0;
      end
      ESPERA_SOLTAR: begin
        if (fim_quadro && !ocupado) estado_nx = LIVRE;
      end
      default: estado_nx = LIVRE;
    endcase
  end

  // Move outputs register alongside the entry into EMITE
  always_ff @(posedge clock) begin
    if (reset) begin
      temJogada     <= 1'b0;
      jogadaFileira <= 3'd0;
      jogadaColuna  <= 3'd0;
    end else begin
      temJogada <= (estado_nx == EMITE);
      if (estado_nx == EMITE) begin
        jogadaFileira <= cand_r_nx;
        jogadaColuna  <= cand_c_nx;
      end
    end
  end

`ifdef VARREDOR_MULTI_ERR_EN
  always_ff @(posedge clock) begin
    if (reset)           multiplo <= 1'b0;
    else if (fim_quadro) multiplo <= (frame_cnt == 2'd2);
  end
`endif

endmodule

// File: tb/tb_varredor_tabuleiro.sv
// Bench for varredor_tabuleiro: frame-level reference model plus directed board scenarios.
module tb_varredor_tabuleiro;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEBOUNCE = 3;
  localparam int FRAME = 8 * SCAN_DIV;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] linhaAtiva;
  logic [7:0] colunasLidas;
  logic [2:0] jogadaFileira, jogadaColuna;
  logic       temJogada;
  logic [3:0] db_estado;
`ifdef VARREDOR_MULTI_ERR_EN
  logic       multiplo;
`endif

  logic [7:0] board [8];

  varredor_tabuleiro #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clock(clock),
    .reset(reset),
    .linhaAtiva(linhaAtiva),
    .colunasLidas(colunasLidas),
    .jogadaFileira(jogadaFileira),
    .jogadaColuna(jogadaColuna),
    .temJogada(temJogada),
    .db_estado(db_estado)
`ifdef VARREDOR_MULTI_ERR_EN
    ,
    .multiplo(multiplo)
`endif
  );

  always #5 clock = ~clock;

  // Physical board: a pressed square shorts its driven row onto its column
  always_comb begin
    colunasLidas = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (linhaAtiva[i]) colunasLidas = colunasLidas | board[i];
    end
  end

  // Reference model: cycle index since reset, frame snapshots, press streak
  int         m_k, m_row, m_n, m_fr, m_fc, m_streak, m_cr, m_cc, m_fil, m_col;
  bit         m_armed, m_emit, m_multi, m_valid = 1'b0;
  logic [7:0] m_d1, m_d2, m_cols;
  logic [7:0] m_rows [8];

  always @(posedge clock) begin
    if (reset) begin
      m_k = 0; m_d1 = 8'd0; m_d2 = 8'd0;
      for (int i = 0; i < 8; i++) m_rows[i] = 8'd0;
      m_streak = 0; m_armed = 1'b1; m_emit = 1'b0; m_multi = 1'b0;
      m_fil = 0; m_col = 0; m_cr = 0; m_cc = 0; m_valid = 1'b1;
    end else begin
      m_row  = (m_k / SCAN_DIV) % 8;
      m_cols = board[m_row];
      m_emit = 1'b0;
      if (m_k % SCAN_DIV == SCAN_DIV - 1) begin
        m_rows[m_row] = m_d2;
        if (m_row == 7) begin
          m_n = 0; m_fr = 0; m_fc = 0;
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
              if (m_rows[r][c]) begin
                if (m_n == 0) begin m_fr = r; m_fc = c; end
                m_n++;
              end
          for (int r = 0; r < 8; r++) m_rows[r] = 8'd0;
`ifdef VARREDOR_MULTI_ERR_EN
          m_multi = (m_n >= 2);
          if (m_n >= 2) m_streak = 0;
          else
`endif
          if (m_n == 0) begin
            m_streak = 0;
            m_armed  = 1'b1;
          end else begin
            if (m_streak > 0 && m_fr == m_cr && m_fc == m_cc) m_streak++;
            else begin m_streak = 1; m_cr = m_fr; m_cc = m_fc; end
            if (m_armed && m_streak == DEBOUNCE) begin
              m_emit = 1'b1; m_armed = 1'b0; m_fil = m_fr; m_col = m_fc;
            end
          end
        end
      end
      m_d2 = m_d1;
      m_d1 = m_cols;
      m_k++;
    end
  end

  int n_vec = 0, n_bad = 0, pulsos = 0;
  bit rec = 1'b0;
  int seq[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Advance n cycles, comparing every output against the model at each negedge
  task automatic ciclos(input int n);
    int exp_db;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (m_valid) begin
        exp_db = m_emit ? 2 : (!m_armed ? 3 : (m_streak > 0 ? 1 : 0));
        chk("linhaAtiva", int'(linhaAtiva), 1 << ((m_k / SCAN_DIV) % 8));
        chk("temJogada", int'(temJogada), int'(m_emit));
        chk("jogadaFileira", int'(jogadaFileira), m_fil);
        chk("jogadaColuna", int'(jogadaColuna), m_col);
        chk("db_estado", int'(db_estado), exp_db);
`ifdef VARREDOR_MULTI_ERR_EN
        chk("multiplo", int'(multiplo), int'(m_multi));
`endif
      end
      if (temJogada) pulsos++;
      if (rec && (seq.size() == 0 || seq[$] != int'(db_estado))) seq.push_back(int'(db_estado));
    end
  endtask

  task automatic limpa();
    for (int i = 0; i < 8; i++) board[i] = 8'd0;
  endtask

  task automatic poe(input int r, input int c, input logic v);
    board[r][c] = v;
  endtask

  int exp_seq [5] = '{3, 0, 1, 2, 3};
  bit achou;

  initial begin
    reset = 1'b1;
    limpa();

    // 1: reset values and row rotation
    ciclos(2);
    chk("rst_linha", int'(linhaAtiva), 8'h01);
    chk("rst_tem", int'(temJogada), 0);
    chk("rst_fil", int'(jogadaFileira), 0);
    chk("rst_col", int'(jogadaColuna), 0);
    chk("rst_db", int'(db_estado), 0);
    reset = 1'b0;
    ciclos(4);
    chk("row1", int'(linhaAtiva), 8'h02);
    ciclos(24);
    chk("row7", int'(linhaAtiva), 8'h80);
    ciclos(4);
    chk("row_wrap", int'(linhaAtiva), 8'h01);

    // 2: stable press of (5,2)
    poe(5, 2, 1'b1);
    ciclos(4 * FRAME);
    chk("t2_pulses", pulsos, 1);
    chk("t2_fil", int'(jogadaFileira), 5);
    chk("t2_col", int'(jogadaColuna), 2);
    ciclos(10 * FRAME);
    chk("t2_hold_pulses", pulsos, 1);

    // 3: release one frame then press (1,7)
    rec = 1'b1;
    seq.push_back(int'(db_estado));
    limpa();
    ciclos(FRAME);
    poe(1, 7, 1'b1);
    ciclos(5 * FRAME);
    rec = 1'b0;
    chk("t3_seq_len", seq.size(), 5);
    for (int i = 0; i < seq.size() && i < 5; i++) chk("t3_seq", seq[i], exp_seq[i]);
    chk("t3_pulses", pulsos, 2);
    chk("t3_fil", int'(jogadaFileira), 1);
    chk("t3_col", int'(jogadaColuna), 7);

    // 4: bouncing (3,3)
    limpa();
    ciclos(2 * FRAME);
    for (int i = 0; i < 6; i++) begin
      poe(3, 3, 1'b1);
      ciclos(FRAME);
      limpa();
      ciclos(FRAME);
    end
    chk("t4_pulses", pulsos, 2);
    chk("t4_fil", int'(jogadaFileira), 1);
    chk("t4_col", int'(jogadaColuna), 7);

    // 5: (2,4) and (6,1) together
    poe(2, 4, 1'b1);
    poe(6, 1, 1'b1);
    ciclos(5 * FRAME);
`ifdef VARREDOR_MULTI_ERR_EN
    chk("t5_multi_pulses", pulsos, 2);
    chk("t5_multi_set", int'(multiplo), 1);
    poe(6, 1, 1'b0);
    ciclos(2 * FRAME);
    chk("t5_multi_clr", int'(multiplo), 0);
    ciclos(4 * FRAME);
`endif
    chk("t5_pulses", pulsos, 3);
    chk("t5_fil", int'(jogadaFileira), 2);
    chk("t5_col", int'(jogadaColuna), 4);
    limpa();
    ciclos(2 * FRAME);

    // 6: reset while confirming (0,0)
    poe(0, 0, 1'b1);
    achou = 1'b0;
    for (int i = 0; i < 4 * FRAME && !achou; i++) begin
      ciclos(1);
      if (m_armed && m_streak == 2) achou = 1'b1;
    end
    chk("t6_second_frame_seen", int'(achou), 1);
    ciclos(1);
    reset = 1'b1;
    ciclos(1);
    reset = 1'b0;
    chk("t6_db", int'(db_estado), 0);
    chk("t6_linha", int'(linhaAtiva), 8'h01);
    chk("t6_fil_rst", int'(jogadaFileira), 0);
    chk("t6_no_pulse", pulsos, 3);
    ciclos(3 * FRAME - 1);
    chk("t6_before_pulse", pulsos, 3);
    ciclos(5);
    chk("t6_pulses", pulsos, 4);
    chk("t6_fil", int'(jogadaFileira), 0);
    chk("t6_col", int'(jogadaColuna), 0);
    limpa();
    ciclos(2 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/varredor_tabuleiro.md
# varredor_tabuleiro

Scans the sensor matrix of the physical chess board, debounces it, and produces the move interface consumed by the game datapath: a 3-bit row (`jogadaFileira`), a 3-bit column (`jogadaColuna`) and a one-cycle `temJogada` strobe. The block sits between the board pins and the game top level. Exactly one strobe is emitted per stable single-square press, and a new strobe requires the board to be released first.

## Interface
- `SCAN_DIV`, default 4: clock cycles each row stays driven; must be ≥ 4.
- `DEBOUNCE`, default 3: number of consecutive identical full-board frames required to accept a press; must be ≥ 2.
- `clock` input 1: system clock, single clock domain.
- `reset` input 1: synchronous, active-high.
- `linhaAtiva` output 8: one-hot row drive, active high.
- `colunasLidas` input 8: column sense lines, asynchronous; bit c high means square (current row, c) is pressed.
- `jogadaFileira` output 3: accepted row, held until the next accepted move.
- `jogadaColuna` output 3: accepted column, held until the next accepted move.
- `temJogada` output 1: one-cycle strobe marking a new accepted move.
- `db_estado` output 4: FSM state for the debug display.
- `multiplo` output 1: present only with `VARREDOR_MULTI_ERR_EN`.

## Operation
- `colunasLidas` passes through a 2-flop synchronizer before use.
- **Scan counters**
  - Divider `d` counts 0..SCAN_DIV-1. Row `r` counts 0..7 and increments when `d` wraps.
  - `r` wraps 7→0 without a gap.
  - `linhaAtiva = 1 << r`.
- **Sampling**
  - The synchronized columns are sampled when `d == SCAN_DIV-1`.
  - Per frame, the block accumulates the pressed-square count (saturating at 2) and the first pressed square in row-major order (lowest row first, then lowest column).
- **Frame end**
  - A frame ends on the sample of row 7.
  - The frame result is EMPTY, SINGLE(r,c) or MULTI, and is computed including row 7's sample.
  - Accumulators clear for the next frame.
- **FSM** (`db_estado` encoding in parentheses); transitions are evaluated only at frame end, except in EMITE.
  - LIVRE (0): SINGLE → CONFIRMA, candidate = (r,c), cnt = 1. Otherwise stay.
  - CONFIRMA (1):
    - SINGLE matching the candidate → cnt+1; when cnt reaches DEBOUNCE → EMITE.
    - SINGLE of a different square → candidate = new square, cnt = 1.
    - EMPTY → LIVRE.
    - MULTI → see Configuration.
  - EMITE (2): lasts one cycle.
    - `temJogada` = 1; `jogadaFileira` / `jogadaColuna` load the candidate.
    - Next state is ESPERA_SOLTAR.
  - ESPERA_SOLTAR (3): EMPTY → LIVRE; otherwise stay. Holding the piece never re-triggers a strobe.
- `cnt` is ⌈log2(DEBOUNCE+1)⌉ bits wide and never exceeds DEBOUNCE.

## Timing
- Reset values:
  - `linhaAtiva = 8'b0000_0001`, `r = 0`, `d = 0`.
  - `jogadaFileira = 0`, `jogadaColuna = 0`, `temJogada = 0`, `multiplo = 0`.
  - Synchronizer flops cleared, `db_estado = 0` (LIVRE).
- Frame length is 8·SCAN_DIV cycles (32 with defaults).
- With the input already synchronized, data sampled at `d = SCAN_DIV-1` reflects the current row. SCAN_DIV ≥ 4 covers the 2-cycle synchronizer plus settling.
- `temJogada` goes high in the cycle immediately after the clock edge of the DEBOUNCE-th matching frame-end sample.
  - Minimum press-to-strobe latency is DEBOUNCE frames plus up to one partial frame.
  - `temJogada` is never high for two consecutive cycles.
- `jogadaFileira` / `jogadaColuna` change only in the EMITE cycle, and are valid in that same cycle.
- Reset asserted mid-frame or mid-CONFIRMA discards the partial frame and candidate; no strobe is emitted. Scanning restarts at row 0 in the cycle after reset deasserts.
- Scanning never stops in any FSM state.

## Configuration
- Macro: `VARREDOR_MULTI_ERR_EN`.
- **Defined:**
  - A MULTI frame in LIVRE or CONFIRMA → LIVRE, cnt cleared, no strobe.
  - `multiplo` is a registered flag: it goes to 1 at the frame end of a MULTI frame and to 0 at the frame end of any non-MULTI frame.
- **Undefined:**
  - The `multiplo` port and its logic are absent.
  - MULTI is treated as SINGLE of the first pressed square (row-major priority).

## Test plan
Use SCAN_DIV = 4 and DEBOUNCE = 3 throughout.

1. **Reset:** hold `reset` 2 cycles → `linhaAtiva = 01h`, `temJogada = 0`, `jogadaFileira = 0`, `jogadaColuna = 0`, `db_estado = 0`. Rows then cycle 01h→02h→…→80h→01h, changing every 4 cycles.
2. **Stable press:** hold (5,2) → exactly one `temJogada` pulse with `jogadaFileira = 5`, `jogadaColuna = 2`, within 4 frames (128 cycles). No further pulse while (5,2) is held for 10 frames.
3. **Release and re-press:** release 1 frame, then press (1,7) → `db_estado` passes 3→0→1→2. One pulse with `jogadaFileira = 1`, `jogadaColuna = 7`.
4. **Bounce:** press (3,3) for 1 frame, release 1 frame, repeated 6 times → no pulse, and `jogadaFileira` / `jogadaColuna` unchanged.
5. **Two squares:** press (2,4) and (6,1) together.
   - Macro undefined → one pulse with `jogadaFileira = 2`, `jogadaColuna = 4`.
   - Macro defined → no pulse, `multiplo = 1`; `multiplo` returns to 0 one frame after (6,1) is released. A pulse for (2,4) then follows 3 frames later.
6. **Reset in CONFIRMA:** press (0,0), assert `reset` 1 cycle after the second matching frame → no pulse, `db_estado = 0`, scan restarts at row 0. The pulse for (0,0) then arrives after 3 fresh frames.
